// File: rtl/tap_pkg.sv
// Shared TAP controller types: the 16 IEEE 1149.1 states in a 4-bit encoding.
package tap_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam int TAP_NUM_STATES = 16;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP controller: Moore FSM, one registered state, one-hot state outputs.
module tap_fsm
    import tap_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tms,
    output logic test_logic_reset,
    output logic run_test_idle,
    output logic select_dr_scan,
    output logic capture_dr,
    output logic shift_dr,
    output logic exit1_dr,
    output logic pause_dr,
    output logic exit2_dr,
    output logic update_dr,
    output logic select_ir_scan,
    output logic capture_ir,
    output logic shift_ir,
    output logic exit1_ir,
    output logic pause_ir,
    output logic exit2_ir,
    output logic update_ir
);

    tap_state_t                      state, state_nxt;
    logic [TAP_NUM_STATES-1:0]       dec;

    always_ff @(posedge clk) begin
        if (reset) state <= TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = TLR;
        case (state)
            TLR:      state_nxt = tms ? TLR      : RTI;
            RTI:      state_nxt = tms ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_nxt = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_nxt = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_nxt = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_nxt = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_nxt = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_nxt = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
            // Unreachable with a full 4-bit enum, kept so a corrupted state recovers.
            default:  state_nxt = TLR;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec[state] = 1'b1;
    end

    assign test_logic_reset = dec[TLR];
    assign run_test_idle    = dec[RTI];
    assign select_dr_scan   = dec[SEL_DR];
    assign capture_dr       = dec[CAP_DR];
    assign shift_dr         = dec[SHIFT_DR];
    assign exit1_dr         = dec[EXIT1_DR];
    assign pause_dr         = dec[PAUSE_DR];
    assign exit2_dr         = dec[EXIT2_DR];
    assign update_dr        = dec[UPD_DR];
    assign select_ir_scan   = dec[SEL_IR];
    assign capture_ir       = dec[CAP_IR];
    assign shift_ir         = dec[SHIFT_IR];
    assign exit1_ir         = dec[EXIT1_IR];
    assign pause_ir         = dec[PAUSE_IR];
    assign exit2_ir         = dec[EXIT2_IR];
    assign update_ir        = dec[UPD_IR];

endmodule

// File: tb/tb_tap_fsm.sv
// Bench for tap_fsm: scenario vector table plus reset corner cases and a 16-state recovery sweep.
module tb_tap_fsm;

    logic clk = 1'b0;
    logic reset, tms;
    logic test_logic_reset, run_test_idle, select_dr_scan, capture_dr, shift_dr;
    logic exit1_dr, pause_dr, exit2_dr, update_dr, select_ir_scan, capture_ir;
    logic shift_ir, exit1_ir, pause_ir, exit2_ir, update_ir;

    always #5 clk = ~clk;

    tap_fsm dut (
        .clk(clk), .reset(reset), .tms(tms),
        .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
        .select_dr_scan(select_dr_scan), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .exit1_dr(exit1_dr), .pause_dr(pause_dr), .exit2_dr(exit2_dr),
        .update_dr(update_dr), .select_ir_scan(select_ir_scan), .capture_ir(capture_ir),
        .shift_ir(shift_ir), .exit1_ir(exit1_ir), .pause_ir(pause_ir),
        .exit2_ir(exit2_ir), .update_ir(update_ir)
    );

    // Bench-local state numbering: bit i of obs is the output for state i.
    localparam int S_TLR = 0,  S_RTI = 1,  S_SDR = 2,  S_CDR = 3;
    localparam int S_SHD = 4,  S_E1D = 5,  S_PD  = 6,  S_E2D = 7;
    localparam int S_UDR = 8,  S_SIR = 9,  S_CIR = 10, S_SHI = 11;
    localparam int S_E1I = 12, S_PI  = 13, S_E2I = 14, S_UIR = 15;

    logic [15:0] obs;
    assign obs = {update_ir, exit2_ir, pause_ir, exit1_ir, shift_ir, capture_ir,
                  select_ir_scan, update_dr, exit2_dr, pause_dr, exit1_dr, shift_dr,
                  capture_dr, select_dr_scan, run_test_idle, test_logic_reset};

    typedef struct {
        logic rst;
        logic t;
        int   exp_st;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   nxt0[16], nxt1[16];
    int   mdl;
    logic [7:0] path_bits[16];
    int   path_len[16];

    task automatic check_one(input string name, input int exp_st);
        logic [15:0] want;
        want = 16'd1 << exp_st;
        n_total++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: outputs=%016b required=%016b", name, obs, want);
        n_total++;
        if ($onehot(obs)) n_pass++;
        else $display("FAIL %s_onehot: outputs=%016b required exactly one high", name, obs);
    endtask

    // Drive away from the active edge, queue the expectation, compare just after the edge.
    task automatic step(input logic r, input logic t, input int exp_st, input string name);
        int e;
        @(negedge clk);
        reset = r;
        tms   = t;
        exp_q.push_back(exp_st);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_one(name, e);
    endtask

    task automatic add(input logic r, input logic t, input int s);
        vec_t v;
        v.rst = r; v.t = t; v.exp_st = s;
        vecs.push_back(v);
    endtask

    // Model-driven step: expectation comes from the bench's own transition table.
    task automatic mstep(input logic t, input string name);
        mdl = t ? nxt1[mdl] : nxt0[mdl];
        step(1'b0, t, mdl, name);
    endtask

    initial begin
        nxt0 = '{S_RTI, S_RTI, S_CDR, S_SHD, S_SHD, S_PD,  S_PD,  S_SHD,
                 S_RTI, S_CIR, S_SHI, S_SHI, S_PI,  S_PI,  S_SHI, S_RTI};
        nxt1 = '{S_TLR, S_SDR, S_SIR, S_E1D, S_E1D, S_UDR, S_E2D, S_UDR,
                 S_SDR, S_TLR, S_E1I, S_E1I, S_UIR, S_E2I, S_UIR, S_SDR};
        // Shortest tms route from TLR to each state, bit 0 applied first.
        path_len  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
        path_bits = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                      8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};

        reset = 1'b1;
        tms   = 1'b0;

        // Reset hold/release, then DR path, DR pause loop and IR path.
        repeat (4) add(1, 0, S_TLR);
        add(0, 1, S_TLR); add(0, 0, S_RTI);
        add(0, 1, S_SDR); add(0, 0, S_CDR); add(0, 0, S_SHD);
        add(0, 1, S_E1D); add(0, 1, S_UDR); add(0, 0, S_RTI);
        add(0, 1, S_SDR); add(0, 0, S_CDR); add(0, 0, S_SHD);
        add(0, 1, S_E1D); add(0, 0, S_PD);  add(0, 1, S_E2D);
        add(0, 0, S_SHD); add(0, 1, S_E1D); add(0, 1, S_UDR);
        add(0, 0, S_RTI);
        add(0, 1, S_SDR); add(0, 1, S_SIR); add(0, 0, S_CIR); add(0, 0, S_SHI);
        add(0, 1, S_E1I); add(0, 0, S_PI);  add(0, 1, S_E2I); add(0, 1, S_UIR);
        add(0, 1, S_SDR);

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].t, vecs[i].exp_st, $sformatf("vec%0d", i));

        // Reset mid IR scan with tms=0, then release with tms=0 into RTI.
        step(0, 1, S_SIR, "to_sel_ir");
        step(0, 0, S_CIR, "to_cap_ir");
        step(0, 0, S_SHI, "to_shift_ir");
        step(1, 0, S_TLR, "rst_in_shift_ir");
        step(0, 0, S_RTI, "release_to_rti");

        // Reset mid DR scan with tms=1 and reset overriding tms in RTI.
        step(0, 1, S_SDR, "to_sel_dr");
        step(0, 0, S_CDR, "to_cap_dr");
        step(0, 0, S_SHD, "to_shift_dr");
        step(1, 1, S_TLR, "rst_in_shift_dr");
        step(0, 0, S_RTI, "rti_again");
        step(1, 0, S_TLR, "rst_in_rti");

        // Every state reaches TLR within five tms=1 edges.
        for (int s = 0; s < 16; s++) begin
            step(1, 0, S_TLR, $sformatf("sweep_rst_%0d", s));
            mdl = S_TLR;
            for (int k = 0; k < path_len[s]; k++)
                mstep(path_bits[s][k], $sformatf("walk_to_%0d", s));
            for (int k = 0; k < 5; k++)
                mstep(1'b1, $sformatf("recover_%0d_%0d", s, k));
            n_total++;
            if (test_logic_reset === 1'b1) n_pass++;
            else $display("FAIL recover_tlr_%0d: test_logic_reset=%b required=1", s, test_logic_reset);
        end

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tap_fsm.md
TAP_FSM -- requirements
Module: tap_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port order SHALL match the list below (positional instantiation).
REQ-004 clk  input  1  TCK-equivalent clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous active-high reset; forces Test-Logic-Reset.
REQ-006 tms  input  1  JTAG test-mode-select, sampled on rising clk.
REQ-007 test_logic_reset, run_test_idle, select_dr_scan, capture_dr, shift_dr SHALL each be an output, 1 bit wide, high while the FSM is in that state.
REQ-008 exit1_dr, pause_dr, exit2_dr, update_dr, select_ir_scan, capture_ir SHALL each be an output, 1 bit wide, high while the FSM is in that state.
REQ-009 shift_ir, exit1_ir, pause_ir, exit2_ir, update_ir SHALL each be an output, 1 bit wide, high while the FSM is in that state.

Function
REQ-010 The block SHALL implement the 16-state IEEE 1149.1 TAP controller as a Moore FSM with one registered state variable.
REQ-011 The 16 outputs SHALL be a one-hot decode of the current state: exactly one is high in every cycle, and there is no dependency on tms within a cycle.
REQ-012 A state change SHALL occur only at a rising clk edge and SHALL be visible on the outputs in that same cycle (latency 1 edge from tms sample).
REQ-013 Transitions SHALL be written as (tms=0 / tms=1), as follows:
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- CapDR: ShiftDR / Exit1DR
- ShiftDR: ShiftDR / Exit1DR
- Exit1DR: PauseDR / UpdDR
- PauseDR: PauseDR / Exit2DR
- Exit2DR: ShiftDR / UpdDR
- UpdDR: RTI / SelDR
REQ-014 IR-side transitions SHALL be as follows:
- SelIR: CapIR / TLR
- CapIR: ShiftIR / Exit1IR
- ShiftIR: ShiftIR / Exit1IR
- Exit1IR: PauseIR / UpdIR
- PauseIR: PauseIR / Exit2IR
- Exit2IR: ShiftIR / UpdIR
- UpdIR: RTI / SelDR
REQ-015 From any state, five consecutive rising edges with tms=1 SHALL reach TLR.
REQ-016 An X or Z value on tms SHALL not be required to be handled; the default/illegal state encoding SHALL return to TLR on the next edge.

Reset
REQ-017 Reset SHALL take priority over tms; the next state is TLR regardless of the current state.
REQ-018 After a reset edge, test_logic_reset SHALL be 1 and all other outputs SHALL be 0.
REQ-019 Reset asserted mid-scan (e.g., in ShiftDR) SHALL abort the scan to TLR at the next edge.
REQ-020 Deasserting reset with tms=0 SHALL move the FSM to RTI on the following edge.

Structure
REQ-021 A shared package (tap_pkg) SHALL hold a 4-bit enumerated typedef tap_state_t with the 16 state names.
REQ-022 The block SHALL be a single module with no sub-modules.
REQ-023 The block SHALL contain one sequential process (state register) and combinational next-state and output-decode logic.

Verification
REQ-024 Reset scenario: hold reset=1 for 4 edges, then release with tms=1 for 1 edge -> test_logic_reset=1 throughout; tms=0 next edge -> run_test_idle=1.
REQ-025 DR path scenario: from RTI apply tms 1,0,0,1,1,0 -> state sequence SelDR, CapDR, ShiftDR, Exit1DR, UpdDR, RTI.
REQ-026 DR pause scenario: from ShiftDR apply tms 1,0,1,0,1,1 -> state sequence Exit1DR, PauseDR, Exit2DR, ShiftDR, Exit1DR, UpdDR.
REQ-027 IR path scenario: from RTI apply tms 1,1,0,0,1,0,1,1 -> state sequence SelDR, SelIR, CapIR, ShiftIR, Exit1IR, PauseIR, Exit2IR, UpdIR; then tms=1 -> SelDR.
REQ-028 Recovery scenario: from each of the 16 states apply five edges with tms=1 -> test_logic_reset=1; on every cycle of every test, exactly one output is high.
REQ-029 Reset mid-scan scenario: in ShiftIR assert reset with tms=0 -> TLR on the next edge.
